// File: rtl/mux_pkg.sv
// mux_pkg -- shared constants for the registered channel multiplexer.
//   MODE_FIXED : channel chosen directly by SEL
//   MODE_RR    : round-robin among channels presenting valid data
//   chw()      : width of a channel index for a given channel count
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Channel-index width; never narrower than one bit.
  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin grant.
//   req     : request vector, one bit per channel
//   ptr     : index of the last granted channel
//   gnt     : one-hot grant (zero when nothing is requested)
//   gnt_idx : binary index of the granted channel
//   gnt_vld : a grant was issued
// The search starts at ptr+1 and wraps from NCH-1 to 0.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx,
  output logic           gnt_vld
);

  logic [CHW-1:0] start;
  logic [CHW-1:0] hi_idx;
  logic [CHW-1:0] lo_idx;
  logic           hi_found;
  logic           lo_found;

  // Split the requests into those at or above the start point and those
  // below it; the lowest request in the upper half wins, otherwise the
  // lowest request in the lower half (the wrapped part of the search).
  // The loop runs downward so the last assignment is the lowest index.
  always_comb begin
    start    = (ptr == CHW'(NCH - 1)) ? '0 : ptr + 1'b1;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (CHW'(j) >= start) begin
          hi_found = 1'b1;
          hi_idx   = CHW'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = CHW'(j);
        end
      end
    end
    gnt_vld = hi_found | lo_found;
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt     = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_reg.sv
// mux_rr_reg -- NCH-to-1 valid/ready multiplexer with a single output register.
//   CLK, RST          : clock, synchronous active-high reset
//   SEL               : channel select (fixed mode only)
//   IN_VALID/IN_READY : per-channel handshake; IN_READY is one-hot or zero
//   IN_DATA           : channel k at [k*WIDTH +: WIDTH]
//   OUT_VALID/OUT_READY, OUT_DATA, OUT_CH : registered output and its source channel
// IN_READY depends only on IN_VALID, SEL, OUT_READY and registered state;
// IN_DATA reaches outputs only through the output register.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  localparam int CHW  = chw(NCH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CHW-1:0]       SEL,
  input  logic [NCH-1:0]       IN_VALID,
  input  logic [NCH*WIDTH-1:0] IN_DATA,
  output logic [NCH-1:0]       IN_READY,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic [CHW-1:0]       OUT_CH,
  input  logic                 OUT_READY
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CHW-1:0]   out_ch_q,    out_ch_d;
  logic [CHW-1:0]   ptr_q,       ptr_d;

  logic [NCH-1:0]   rr_gnt;
  logic [CHW-1:0]   rr_idx;
  logic             rr_vld;
  logic [NCH-1:0]   fix_gnt;
  logic             sel_ok;
  logic [NCH-1:0]   gnt_oh;
  logic [CHW-1:0]   gnt_idx;
  logic             space;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req     (IN_VALID),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Fixed mode: an out-of-range SEL grants nothing, whatever IN_VALID says.
  always_comb begin
    sel_ok  = ({1'b0, SEL} < (CHW + 1)'(NCH));
    fix_gnt = '0;
    if (sel_ok) fix_gnt[SEL] = 1'b1;
  end

  // Grant is offered only when the register is empty or drains this cycle.
  always_comb begin
    space    = !out_valid_q || OUT_READY;
    gnt_oh   = (MODE == MODE_RR) ? (rr_vld ? rr_gnt : '0) : fix_gnt;
    gnt_idx  = (MODE == MODE_RR) ? rr_idx : SEL;
    IN_READY = (RST || !space) ? '0 : gnt_oh;
    xfer     = |(IN_READY & IN_VALID);
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx == CHW'(k)) sel_data = IN_DATA[k*WIDTH +: WIDTH];
    end
  end

  // A load takes priority over a drain, giving back-to-back transfers.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = gnt_idx;
      if (MODE == MODE_RR) ptr_d = gnt_idx;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer resets to the top channel so channel 0 is searched first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= CHW'(NCH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg -- three instances (fixed/4ch, round-robin/4ch, fixed/5ch)
// run in lockstep against a queue-free behavioural model of the mux rules.
module tb_mux_rr_reg;

  logic clk = 1'b0;
  logic rst;
  logic armed;
  always #5 clk = ~clk;

  // Per-instance stimulus; instance 2 has five channels and a 3-bit SEL.
  logic [2:0]  sel_a [3];
  logic [4:0]  vld_a [3];
  logic [31:0] dat_a [3][5];
  logic        ordy  [3];

  logic [3:0]  rdy0, rdy1;
  logic [4:0]  rdy2;
  logic        ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  oc0, oc1;
  logic [2:0]  oc2;

  mux_rr_reg #(.WIDTH(32), .NCH(4), .MODE(0)) u0 (
    .CLK(clk), .RST(rst), .SEL(sel_a[0][1:0]), .IN_VALID(vld_a[0][3:0]),
    .IN_DATA({dat_a[0][3], dat_a[0][2], dat_a[0][1], dat_a[0][0]}),
    .IN_READY(rdy0), .OUT_VALID(ov0), .OUT_DATA(od0), .OUT_CH(oc0), .OUT_READY(ordy[0]));

  mux_rr_reg #(.WIDTH(32), .NCH(4), .MODE(1)) u1 (
    .CLK(clk), .RST(rst), .SEL(sel_a[1][1:0]), .IN_VALID(vld_a[1][3:0]),
    .IN_DATA({dat_a[1][3], dat_a[1][2], dat_a[1][1], dat_a[1][0]}),
    .IN_READY(rdy1), .OUT_VALID(ov1), .OUT_DATA(od1), .OUT_CH(oc1), .OUT_READY(ordy[1]));

  mux_rr_reg #(.WIDTH(32), .NCH(5), .MODE(0)) u2 (
    .CLK(clk), .RST(rst), .SEL(sel_a[2]), .IN_VALID(vld_a[2]),
    .IN_DATA({dat_a[2][4], dat_a[2][3], dat_a[2][2], dat_a[2][1], dat_a[2][0]}),
    .IN_READY(rdy2), .OUT_VALID(ov2), .OUT_DATA(od2), .OUT_CH(oc2), .OUT_READY(ordy[2]));

  logic [4:0]  rdy_o [3];
  logic        ov_o  [3];
  logic [31:0] od_o  [3];
  logic [2:0]  oc_o  [3];
  always_comb begin
    rdy_o[0] = {1'b0, rdy0}; rdy_o[1] = {1'b0, rdy1}; rdy_o[2] = rdy2;
    ov_o[0]  = ov0;          ov_o[1]  = ov1;          ov_o[2]  = ov2;
    od_o[0]  = od0;          od_o[1]  = od1;          od_o[2]  = od2;
    oc_o[0]  = {1'b0, oc0};  oc_o[1]  = {1'b0, oc1};  oc_o[2]  = oc2;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d @%0t: got %h, expected %h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          nch_m  [3] = '{4, 4, 5};
  int          mode_m [3] = '{0, 1, 0};
  int          m_ptr  [3] = '{3, 3, 4};
  logic        m_v    [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] m_d    [3] = '{32'h0, 32'h0, 32'h0};
  int          m_c    [3] = '{0, 0, 0};

  // Channel that may transfer this cycle, or -1.
  function automatic int model_grant(input int mode, input int n, input int s,
                                     input logic [4:0] v, input int last);
    if (mode == 0) return (s < n) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        int         g;
        logic [4:0] exp_rdy;
        g = model_grant(mode_m[i], nch_m[i], int'(sel_a[i]), vld_a[i], m_ptr[i]);
        exp_rdy = (rst || g < 0 || (m_v[i] && !ordy[i])) ? 5'b0 : (5'b1 << g);
        chk("in_ready", i, 32'(rdy_o[i]), 32'(exp_rdy));
        chk("out_valid", i, 32'(ov_o[i]), 32'(m_v[i]));
        if (m_v[i]) begin
          chk("out_data", i, od_o[i], m_d[i]);
          chk("out_ch", i, 32'(oc_o[i]), 32'(m_c[i]));
        end
        // advance model to the state after the coming rising edge
        if (rst) begin
          m_v[i] = 1'b0; m_d[i] = '0; m_c[i] = 0; m_ptr[i] = nch_m[i] - 1;
        end else if ((exp_rdy & vld_a[i]) != 5'b0) begin
          m_v[i] = 1'b1; m_d[i] = dat_a[i][g]; m_c[i] = g;
          if (mode_m[i] == 1) m_ptr[i] = g;
        end else if (ordy[i]) begin
          m_v[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      sel_a[i] = '0; vld_a[i] = '0; ordy[i] = 1'b1;
      for (int k = 0; k < 5; k++) dat_a[i][k] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; armed = 1'b0;
    idle_all();
    step();
    armed = 1'b1;
    step();
    rst = 1'b0;

    // Fixed select of channel 2
    sel_a[0] = 3'd2; vld_a[0] = 5'b00100; dat_a[0][2] = 32'hDEADBEEF;
    @(negedge clk); chk("lit_rdy_sel2", 0, 32'(rdy0), 32'h4);
    step(); vld_a[0] = '0;
    @(negedge clk);
    chk("lit_ov_sel2", 0, 32'(ov0), 32'h1);
    chk("lit_od_sel2", 0, od0, 32'hDEADBEEF);
    chk("lit_oc_sel2", 0, 32'(oc0), 32'h2);
    step();

    // Round-robin over all four channels
    do_reset();
    vld_a[1] = 5'b01111;
    for (int k = 0; k < 5; k++) begin
      dat_a[1][k % 4] = 32'h100 + 32'(k);
      step(); @(negedge clk);
      chk("lit_rr_all", 1, 32'(oc1), 32'(k % 4));
    end
    step();

    // Round-robin skips idle channels
    do_reset();
    vld_a[1] = 5'b01010;
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge clk);
      chk("lit_rr_skip", 1, 32'(oc1), (k == 1) ? 32'd3 : 32'd1);
    end
    step();
    vld_a[1] = '0;

    // Backpressure holds the register, release loads in the same cycle
    sel_a[0] = 3'd0; vld_a[0] = 5'b00001; dat_a[0][0] = 32'h12345678; ordy[0] = 1'b0;
    step();
    dat_a[0][0] = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_hold_rdy", 0, 32'(rdy0), 32'h0);
      chk("lit_hold_od", 0, od0, 32'h12345678);
      step();
    end
    ordy[0] = 1'b1;
    @(negedge clk); chk("lit_release_rdy", 0, 32'(rdy0), 32'h1);
    step(); vld_a[0] = '0;
    @(negedge clk); chk("lit_release_od", 0, od0, 32'hCAFEF00D);
    step();

    // Out-of-range select on the five-channel instance
    vld_a[2] = 5'b11111;
    for (int s = 5; s < 8; s++) begin
      sel_a[2] = 3'(s);
      @(negedge clk);
      chk("lit_badsel_rdy", 2, 32'(rdy2), 32'h0);
      chk("lit_badsel_ov", 2, 32'(ov2), 32'h0);
      step();
    end
    vld_a[2] = '0; sel_a[2] = '0;

    // Reset while full and stalled; pointer must return to the top
    vld_a[1] = 5'b00001; dat_a[1][0] = 32'hAAAA5555; ordy[1] = 1'b0;
    step(); vld_a[1] = '0;
    @(negedge clk); chk("lit_full_ov", 1, 32'(ov1), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    vld_a[1] = 5'b00101;
    @(negedge clk);
    chk("lit_rst_ov", 1, 32'(ov1), 32'h0);
    chk("lit_rst_od", 1, od1, 32'h0);
    chk("lit_rst_rdy", 1, 32'(rdy1), 32'h1);
    step(); vld_a[1] = '0; ordy[1] = 1'b1;
    @(negedge clk); chk("lit_rst_oc", 1, 32'(oc1), 32'h0);
    step();

    // Randomised traffic on all instances
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        vld_a[i] = 5'($urandom) & ((i == 2) ? 5'b11111 : 5'b01111);
        sel_a[i] = 3'($urandom_range(0, (i == 2) ? 7 : 3));
        ordy[i]  = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 5; k++) dat_a[i][k] = $urandom;
      end
      step();
    end
    rst = 1'b0; idle_all();
    @(negedge clk);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
